// File: rtl/hwpe_dma_loader.sv
// rtl/hwpe_dma_loader.sv - descriptor-driven loader from 32-bit system memory into hwpe 64-bit SRAM
`ifndef HWPE_ADDR_WIDTH
`define HWPE_ADDR_WIDTH 16
`endif

module hwpe_dma_loader #(
  parameter int DST_AW  = `HWPE_ADDR_WIDTH,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [31:0]       desc_src_addr,
  input  logic [DST_AW-1:0] desc_dst_addr,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [31:0]       mem_cmd_addr,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              dma_wen,
  output logic [DST_AW-1:0] dma_wa,
  output logic [63:0]       dma_wd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int         CW        = LEN_W + 1;
  localparam logic [2:0] MAX_OUT_V = 3'(MAX_OUT);

  state_t            state;
  logic [CW-1:0]     total;
  logic [CW-1:0]     cmd_cnt;
  logic [CW-1:0]     rsp_cnt;
  logic [2:0]        outstanding;
  logic [31:0]       cmd_addr;
  logic [31:0]       low_half;
  logic              low_err;
  logic [DST_AW-1:0] next_wa;
  logic              cmd_hs;
  logic              rsp_hs;

  // The address only moves on a handshake, so it stays stable while a command stalls.
  assign mem_cmd_valid = (state == RUN) && (cmd_cnt < total) && (outstanding < MAX_OUT_V);
  assign mem_cmd_addr  = cmd_addr;
  assign mem_rsp_ready = (state == RUN) && (outstanding != 3'd0);
  assign cmd_hs        = mem_cmd_valid && mem_cmd_ready;
  assign rsp_hs        = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      desc_ready  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dma_wen     <= 1'b0;
      dma_wa      <= '0;
      dma_wd      <= '0;
      total       <= '0;
      cmd_cnt     <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
      cmd_addr    <= '0;
      low_half    <= '0;
      low_err     <= 1'b0;
      next_wa     <= '0;
    end else begin
      dma_wen <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          desc_ready <= 1'b1;
          if (desc_valid && desc_ready) begin
            cmd_addr    <= desc_src_addr & ~32'h3;
            next_wa     <= desc_dst_addr & ~DST_AW'(7);
            total       <= {desc_len, 1'b0};
            cmd_cnt     <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            low_err     <= 1'b0;
            err         <= 1'b0;
            desc_ready  <= 1'b0;
            busy        <= 1'b1;
            state       <= (desc_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (cmd_hs) begin
            cmd_cnt  <= cmd_cnt + CW'(1);
            cmd_addr <= cmd_addr + 32'd4;
          end
          if (cmd_hs && !rsp_hs)
            outstanding <= outstanding + 3'd1;
          else if (!cmd_hs && rsp_hs)
            outstanding <= outstanding - 3'd1;
          if (rsp_hs) begin
            rsp_cnt <= rsp_cnt + CW'(1);
            if (mem_rsp_err)
              err <= 1'b1;
            if (!rsp_cnt[0]) begin
              low_half <= mem_rsp_rdata;
              low_err  <= mem_rsp_err;
            end else begin
              // A beat touched by a read error is dropped, but its slot is still consumed.
              dma_wen <= !(low_err || mem_rsp_err);
              dma_wd  <= {mem_rsp_rdata, low_half};
              dma_wa  <= next_wa;
              next_wa <= next_wa + DST_AW'(8);
              if (rsp_cnt == total - CW'(1))
                state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// tb/tb_hwpe_dma_loader.sv - randomized self-checking bench for hwpe_dma_loader
`ifndef KMEM_ADDR_START
`define KMEM_ADDR_START 16'h4000
`endif

module tb_hwpe_dma_loader;

  localparam int DST_AW  = 16;
  localparam int LEN_W   = 16;
  localparam int MAX_OUT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [31:0]       desc_src_addr = '0;
  logic [DST_AW-1:0] desc_dst_addr = '0;
  logic [LEN_W-1:0]  desc_len = '0;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready = 1'b0;
  logic [31:0]       mem_cmd_addr;
  logic              mem_rsp_valid = 1'b0;
  logic              mem_rsp_ready;
  logic [31:0]       mem_rsp_rdata = '0;
  logic              mem_rsp_err = 1'b0;
  logic              dma_wen;
  logic [DST_AW-1:0] dma_wa;
  logic [63:0]       dma_wd;
  logic              busy;
  logic              done;
  logic              err;

  hwpe_dma_loader #(.DST_AW(DST_AW), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr), .desc_len(desc_len),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [DST_AW-1:0] wa; logic [63:0] wd; int c; } wr_t;
  typedef struct { logic [DST_AW-1:0] wa; logic [63:0] wd; } exp_t;

  logic [31:0] mem_ovr [logic [29:0]];
  pend_t       pend_q[$];
  wr_t         wr_q[$];
  exp_t        exp_q[$];
  logic [31:0] cmd_log[$];
  int rsp_num, err_at = -1, outst, max_outst, lat_max = 1, stall_pct = 0, cmdv_cnt, due_n;
  int pass = 0, tot = 0, acc_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a[31:2])) return mem_ovr[a[31:2]];
    return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Expected beats: word pairs from consecutive source words, skipping any pair hit by an error.
  function automatic void build_exp(input logic [31:0] s, input logic [DST_AW-1:0] d,
                                    input int len, input int err_rsp);
    logic [31:0] sa;
    exp_q.delete();
    for (int b = 0; b < len; b++) begin
      sa = (s & ~32'h3) + 32'(8 * b);
      if (err_rsp != 2 * b && err_rsp != 2 * b + 1)
        exp_q.push_back('{DST_AW'((d & ~DST_AW'(7)) + DST_AW'(8 * b)),
                          {mem_word(sa + 32'd4), mem_word(sa)}});
    end
  endfunction

  // Memory responder and write monitor; in-order responses after a random latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      outst = 0;
      mem_cmd_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
    end else begin
      mem_cmd_ready = ($urandom_range(99) >= stall_pct);
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
      mem_rsp_rdata = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) >= stall_pct) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = mem_word(pend_q[0].addr);
        mem_rsp_err = (rsp_num == err_at);
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        void'(pend_q.pop_front());
        rsp_num++;
        outst--;
      end
      if (mem_cmd_valid) cmdv_cnt++;
      if (mem_cmd_valid && mem_cmd_ready) begin
        due_n = cyc + $urandom_range(lat_max, 1);
        if (pend_q.size() > 0 && pend_q[$].due > due_n) due_n = pend_q[$].due;
        pend_q.push_back('{mem_cmd_addr, due_n});
        cmd_log.push_back(mem_cmd_addr);
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
    end
    if (dma_wen) wr_q.push_back('{dma_wa, dma_wd, cyc});
  end

  task automatic start_xfer(input logic [31:0] s, input logic [DST_AW-1:0] d, input int len);
    wr_q.delete();
    cmd_log.delete();
    rsp_num = 0;
    max_outst = 0;
    cmdv_cnt = 0;
    @(negedge clk);
    desc_src_addr = s;
    desc_dst_addr = d;
    desc_len = LEN_W'(len);
    desc_valid = 1'b1;
    for (int i = 0; i < 50 && !desc_ready; i++) @(negedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int dc);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        ok = 1'b1;
        dc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tot++; if (desc_ready !== 1'b1) $display("FAIL reset_desc_ready got %b exp 1", desc_ready); else pass++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass++;
    tot++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass++;
    tot++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass++;
    tot++; if (dma_wen !== 1'b0) $display("FAIL reset_wen got %b exp 0", dma_wen); else pass++;
    tot++; if (mem_cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got %b exp 0", mem_cmd_valid); else pass++;
    tot++; if (mem_rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready got %b exp 0", mem_rsp_ready); else pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int dc;
    mem_ovr[30'h400] = 32'h0302_0100;
    mem_ovr[30'h401] = 32'h0706_0504;
    stall_pct = 0; lat_max = 1; err_at = -1;
    start_xfer(32'h1000, 16'h0040, 1);
    wait_done(ok, dc);
    tot++; if (!ok) $display("FAIL basic_timeout got no done exp done"); else pass++;
    tot++; if (wr_q.size() != 1) $display("FAIL basic_wr_count got %0d exp 1", wr_q.size()); else pass++;
    if (wr_q.size() > 0) begin
      tot++; if (wr_q[0].wa !== 16'h0040) $display("FAIL basic_wa got %h exp 0040", wr_q[0].wa); else pass++;
      tot++; if (wr_q[0].wd !== 64'h0706_0504_0302_0100) $display("FAIL basic_wd got %h exp 0706050403020100", wr_q[0].wd); else pass++;
      tot++; if (dc != wr_q[0].c + 1) $display("FAIL basic_done_lat got %0d exp %0d", dc, wr_q[0].c + 1); else pass++;
    end
    tot++; if (err !== 1'b0) $display("FAIL basic_err got %b exp 0", err); else pass++;
    tot++; if (busy !== 1'b0 || desc_ready !== 1'b0) $display("FAIL basic_done_cycle got busy=%b rdy=%b exp 0,0", busy, desc_ready); else pass++;
    @(negedge clk);
    tot++; if (desc_ready !== 1'b1) $display("FAIL basic_ready_after got %b exp 1", desc_ready); else pass++;
  endtask

  task automatic test_zero_len();
    bit ok; int dc;
    start_xfer($urandom(), DST_AW'($urandom()), 0);
    wait_done(ok, dc);
    tot++; if (!ok || dc != acc_cyc + 2) $display("FAIL zero_done_lat got %0d exp %0d", dc - acc_cyc, 2); else pass++;
    tot++; if (cmdv_cnt != 0) $display("FAIL zero_cmd_valid got %0d exp 0", cmdv_cnt); else pass++;
    tot++; if (wr_q.size() != 0) $display("FAIL zero_writes got %0d exp 0", wr_q.size()); else pass++;
    @(negedge clk);
    tot++; if (desc_ready !== 1'b1) $display("FAIL zero_ready_after got %b exp 1", desc_ready); else pass++;
  endtask

  task automatic test_error();
    bit ok; int dc;
    stall_pct = 20; lat_max = 2; err_at = 5;
    start_xfer(32'h0000_2000, 16'h0100, 4);
    build_exp(32'h0000_2000, 16'h0100, 4, 5);
    wait_done(ok, dc);
    err_at = -1;
    tot++; if (!ok) $display("FAIL error_timeout got no done exp done"); else pass++;
    tot++; if (wr_q.size() != 3) $display("FAIL error_wr_count got %0d exp 3", wr_q.size()); else pass++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      tot++;
      if (wr_q[i].wa !== exp_q[i].wa || wr_q[i].wd !== exp_q[i].wd)
        $display("FAIL error_wr%0d got %h/%h exp %h/%h", i, wr_q[i].wa, wr_q[i].wd, exp_q[i].wa, exp_q[i].wd);
      else pass++;
    end
    repeat (3) @(negedge clk);
    tot++; if (err !== 1'b1) $display("FAIL error_sticky got %b exp 1", err); else pass++;
    start_xfer(32'h0, 16'h0, 0);
    tot++; if (err !== 1'b0) $display("FAIL error_clear got %b exp 0", err); else pass++;
    wait_done(ok, dc);
  endtask

  task automatic test_full_rate();
    bit ok; int dc;
    stall_pct = 0; lat_max = 1; err_at = -1;
    start_xfer(32'h0000_3000, 16'h0200, 8);
    build_exp(32'h0000_3000, 16'h0200, 8, -1);
    wait_done(ok, dc);
    tot++; if (!ok || dc - acc_cyc > 20) $display("FAIL full_rate_time got %0d exp <=20", dc - acc_cyc); else pass++;
    tot++; if (wr_q.size() != 8) $display("FAIL full_rate_count got %0d exp 8", wr_q.size()); else pass++;
    for (int i = 1; i < wr_q.size(); i++) begin
      tot++; if (wr_q[i].c - wr_q[i-1].c != 2) $display("FAIL full_rate_gap%0d got %0d exp 2", i, wr_q[i].c - wr_q[i-1].c); else pass++;
    end
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      tot++;
      if (wr_q[i].wa !== exp_q[i].wa || wr_q[i].wd !== exp_q[i].wd)
        $display("FAIL full_rate_wr%0d got %h/%h exp %h/%h", i, wr_q[i].wa, wr_q[i].wd, exp_q[i].wa, exp_q[i].wd);
      else pass++;
    end
  endtask

  task automatic test_kernel();
    bit ok; int dc; int bad;
    logic [DST_AW-1:0] kdst;
    kdst = DST_AW'(`KMEM_ADDR_START);
    stall_pct = 30; lat_max = 3; err_at = -1;
    start_xfer(32'h0001_0000, kdst, 672);
    build_exp(32'h0001_0000, kdst, 672, -1);
    wait_done(ok, dc);
    tot++; if (!ok) $display("FAIL kernel_timeout got no done exp done"); else pass++;
    tot++; if (wr_q.size() != 672) $display("FAIL kernel_count got %0d exp 672", wr_q.size()); else pass++;
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      tot++;
      if (wr_q[i].wa !== exp_q[i].wa || wr_q[i].wd !== exp_q[i].wd) begin
        if (bad < 5) $display("FAIL kernel_wr%0d got %h/%h exp %h/%h", i, wr_q[i].wa, wr_q[i].wd, exp_q[i].wa, exp_q[i].wd);
        bad++;
      end else pass++;
    end
    tot++; if (max_outst > MAX_OUT) $display("FAIL kernel_outstanding got %0d exp <=%0d", max_outst, MAX_OUT); else pass++;
    tot++; if (cmd_log.size() != 1344) $display("FAIL kernel_cmds got %0d exp 1344", cmd_log.size()); else pass++;
  endtask

  task automatic test_random();
    bit ok; int dc; int len;
    logic [31:0] s; logic [DST_AW-1:0] d;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(24, 1);
      s = ($urandom_range(2) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(63))) : $urandom();
      d = ($urandom_range(2) == 0) ? DST_AW'(16'hFFC0 | 16'($urandom_range(63))) : DST_AW'($urandom());
      stall_pct = $urandom_range(40); lat_max = $urandom_range(4, 1);
      err_at = ($urandom_range(2) == 0) ? $urandom_range(2 * len - 1) : -1;
      start_xfer(s, d, len);
      build_exp(s, d, len, err_at);
      wait_done(ok, dc);
      tot++; if (!ok) $display("FAIL rand%0d_timeout got no done exp done", t); else pass++;
      tot++; if (err !== (err_at >= 0)) $display("FAIL rand%0d_err got %b exp %b", t, err, err_at >= 0); else pass++;
      tot++; if (wr_q.size() != exp_q.size()) $display("FAIL rand%0d_count got %0d exp %0d", t, wr_q.size(), exp_q.size()); else pass++;
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
        tot++;
        if (wr_q[i].wa !== exp_q[i].wa || wr_q[i].wd !== exp_q[i].wd)
          $display("FAIL rand%0d_wr%0d got %h/%h exp %h/%h", t, i, wr_q[i].wa, wr_q[i].wd, exp_q[i].wa, exp_q[i].wd);
        else pass++;
      end
      tot++; if (cmd_log.size() != 2 * len) $display("FAIL rand%0d_cmds got %0d exp %0d", t, cmd_log.size(), 2 * len); else pass++;
      for (int i = 0; i < cmd_log.size(); i++) begin
        tot++;
        if (cmd_log[i] !== (s & ~32'h3) + 32'(4 * i))
          $display("FAIL rand%0d_cmd%0d got %h exp %h", t, i, cmd_log[i], (s & ~32'h3) + 32'(4 * i));
        else pass++;
      end
      err_at = -1;
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int dc;
    stall_pct = 0; lat_max = 1; err_at = -1;
    start_xfer(32'h0000_5000, 16'h0300, 8);
    for (int i = 0; i < 200 && wr_q.size() < 3; i++) @(negedge clk);
    tot++; if (wr_q.size() < 3) $display("FAIL rstmid_progress got %0d exp >=3", wr_q.size()); else pass++;
    rst_n = 1'b0;
    @(negedge clk);
    tot++;
    if (dma_wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || desc_ready !== 1'b1)
      $display("FAIL rstmid_outputs got wen=%b busy=%b done=%b rdy=%b exp 0,0,0,1", dma_wen, busy, done, desc_ready);
    else pass++;
    rst_n = 1'b1;
    @(negedge clk);
    start_xfer(32'h0000_6004, 16'h0408, 1);
    build_exp(32'h0000_6004, 16'h0408, 1, -1);
    wait_done(ok, dc);
    tot++; if (!ok || wr_q.size() != 1) $display("FAIL rstmid_after_count got %0d exp 1", wr_q.size()); else pass++;
    if (wr_q.size() > 0) begin
      tot++;
      if (wr_q[0].wa !== exp_q[0].wa || wr_q[0].wd !== exp_q[0].wd)
        $display("FAIL rstmid_after_wr got %h/%h exp %h/%h", wr_q[0].wa, wr_q[0].wd, exp_q[0].wa, exp_q[0].wd);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_full_rate();
    test_kernel();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
Upstream feeder for the hwpe DMA write port (dma_wen/dma_wa/dma_wd). Accepts one transfer descriptor at a time. For each descriptor it:
- reads 32-bit words from system memory over an ICB-style read channel;
- packs word pairs into 64-bit beats, low word first;
- writes each beat into hwpe fmap/kernel SRAM space at consecutive 8-byte addresses.

It replaces the bench-driven loading of fmap halves and kernel data in real systems.

Parameters:
DST_AW, `HWPE_ADDR_WIDTH, width of dma_wa and desc_dst_addr
LEN_W, 16, width of desc_len (count of 64-bit beats)
MAX_OUT, 2, max outstanding memory read commands (1..7)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  descriptor accepted when valid&ready
desc_src_addr  in  32  byte source address; bits [1:0] ignored (treated as 0)
desc_dst_addr  in  DST_AW  byte destination address; bits [2:0] ignored (treated as 0)
desc_len  in  LEN_W  number of 64-bit beats to move
mem_cmd_valid  out  1  read command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_addr  out  32  word address of read
mem_rsp_valid  in  1  read data valid
mem_rsp_ready  out  1  loader accepts read data
mem_rsp_rdata  in  32  read data
mem_rsp_err  in  1  read error flag for this response
dma_wen  out  1  hwpe SRAM write enable, single-cycle per beat
dma_wa  out  DST_AW  hwpe SRAM byte address
dma_wd  out  64  hwpe SRAM write data
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
err  out  1  sticky: at least one mem_rsp_err in current/last transfer

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; all outputs 0 except desc_ready=1.
  - All counters, error and pending state cleared.
  - Reset mid-transfer abandons the transfer immediately; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - desc_ready=1, mem_cmd_valid=0, mem_rsp_ready=0.
  - Descriptor handshake latches src/dst/len and clears err.
  - len!=0 -> RUN. len==0 -> DONE.
- RUN:
  - desc_ready=0, busy=1, mem_rsp_ready=1 (hwpe write port has no backpressure).
  - Command issue: mem_cmd_valid=1 while cmd_cnt<2*len and outstanding<MAX_OUT.
  - mem_cmd_addr=src+4*cmd_cnt. It is held stable while valid&!ready.
  - cmd_cnt increments on each cmd handshake.
  - outstanding = cmd handshakes minus rsp handshakes. Both events in the same cycle leave it unchanged.
  - Even-numbered response (rsp_cnt[0]=0): data into low-half register.
  - Odd-numbered response:
    - next cycle dma_wen=1, dma_wd={rdata, low_half}, dma_wa=dst+8*beat_idx.
    - beat_idx increments afterwards.
  - Byte order: memory byte at src+k lands in dma_wd[8k+7:8k].
  - Any response with mem_rsp_err=1 sets err. The 64-bit beat containing it is not written (dma_wen stays 0), but dma_wa still advances. The transfer continues to the end.
  - Exit to DONE the cycle after the final odd response is accepted, i.e. together with the last dma_wen.
- DONE:
  - One cycle: done=1, busy=0, desc_ready=0.
  - Next state IDLE. err holds until the next descriptor is accepted.
- Latencies:
  - First mem_cmd_valid in the cycle after descriptor accept.
  - dma_wen exactly 1 cycle after the odd response handshake.
  - done exactly 1 cycle after the last dma_wen.
- Width rules:
  - Counters are LEN_W+1 bits.
  - dst arithmetic wraps modulo 2^DST_AW; src arithmetic wraps modulo 2^32. No error on wrap.
- Responses return in command order (ICB in-order rule). The loader never accepts a response without a matching outstanding command.
- Back-to-back descriptors: a new descriptor is accepted only in IDLE, so minimum gap is 1 cycle (the DONE cycle).

Test Plan:
- Basic 1-beat transfer: desc src=0x1000, dst=0x0040, len=1; mem[0x1000]=0x03020100, mem[0x1004]=0x07060504 -> one dma_wen with wa=0x0040, wd=0x0706050403020100; done pulses 1 cycle later; err=0.
- Kernel-sized transfer: len=672 (5376 bytes), dst=`KMEM_ADDR_START, random mem_cmd_ready stalls -> 672 writes at consecutive +8 addresses, data matches memory; outstanding never exceeds 2; never more than 1344 commands.
- Zero-length: len=0 -> no mem_cmd_valid, no dma_wen; done=1 two cycles after the handshake; desc_ready back to 1 afterwards.
- Error injection: len=4, mem_rsp_err on response #5 -> beats 0,1,3 written at dst, dst+8, dst+24; no write at dst+16; err=1 until next descriptor accept.
- Full-rate pipeline: mem always ready, response 1 cycle after command, MAX_OUT=2, len=8 -> dma_wen every 2nd cycle; transfer completes within 2*8+4 cycles of accept.
- Reset mid-transfer: rst_n=0 after 3 beats of len=8 -> next posedge: dma_wen=0, busy=0, done=0, desc_ready=1; a new len=1 descriptor then completes normally.
